// File: rtl/sparc_ffu_visctl.sv
// VIS control for the FFU: decodes VIS opfs into one-hot datapath selects,
// keeps the per-thread GSR align field and stages each op in a stallable X register.
module sparc_ffu_visctl (
  input  logic       rclk,
  input  logic       reset,
  input  logic       ifu_ffu_vis_vld,
  input  logic [8:0] ifu_ffu_vis_opf,
  input  logic [1:0] ifu_ffu_vis_tid,
  output logic       visctl_ifu_rdy,
  input  logic       gsr_wr_vld,
  input  logic [1:0] gsr_wr_tid,
  input  logic [2:0] gsr_wr_align,
  input  logic       fpu_wb_stall,
  output logic       ctl_vis_sel_add,
  output logic       ctl_vis_sel_log,
  output logic       ctl_vis_sel_align,
  output logic       ctl_vis_add32,
  output logic       ctl_vis_subtract,
  output logic       ctl_vis_cin,
  output logic       ctl_vis_align0,
  output logic       ctl_vis_align2,
  output logic       ctl_vis_align4,
  output logic       ctl_vis_align6,
  output logic       ctl_vis_align_odd,
  output logic       ctl_vis_log_sel_nor,
  output logic       ctl_vis_log_sel_nand,
  output logic       ctl_vis_log_sel_xor,
  output logic       ctl_vis_log_sel_pass,
  output logic       ctl_vis_log_invert_rs1,
  output logic       ctl_vis_log_invert_rs2,
  output logic       ctl_vis_log_constant,
  output logic       ctl_vis_log_pass_const,
  output logic       ctl_vis_log_pass_rs1,
  output logic       ctl_vis_log_pass_rs2,
  output logic       visctl_dp_vld,
  output logic [1:0] visctl_dp_tid,
  output logic       visctl_illegal,
  output logic [1:0] visctl_illegal_tid
);

  typedef struct packed {
    logic sel_add;
    logic sel_log;
    logic sel_align;
    logic add32;
    logic subtract;
    logic cin;
    logic align0;
    logic align2;
    logic align4;
    logic align6;
    logic align_odd;
    logic log_nor;
    logic log_nand;
    logic log_xor;
    logic log_pass;
    logic inv_rs1;
    logic inv_rs2;
    logic constant;
    logic pass_const;
    logic pass_rs1;
    logic pass_rs2;
  } ctl_t;

  // Idle encoding keeps every downstream mux one-hot while X is empty.
  function automatic ctl_t idle_ctl();
    ctl_t c;
    c            = '0;
    c.sel_add    = 1'b1;
    c.align0     = 1'b1;
    c.log_pass   = 1'b1;
    c.pass_const = 1'b1;
    return c;
  endfunction

  logic [2:0] gsr [4];
  logic [2:0] align_eff;
  logic       is_add, is_align, is_log, legal, accept;
  ctl_t       dec, x_ctl;
  logic       x_vld;
  logic [1:0] x_tid;

  assign visctl_ifu_rdy = !(x_vld && fpu_wb_stall);
  assign accept         = ifu_ffu_vis_vld && visctl_ifu_rdy;

  assign is_add   = (ifu_ffu_vis_opf[8:3] == 6'b001010) && !ifu_ffu_vis_opf[0];
  assign is_align = (ifu_ffu_vis_opf == 9'h048);
  assign is_log   = (ifu_ffu_vis_opf[8:5] == 4'b0011) && !ifu_ffu_vis_opf[0];
  assign legal    = is_add || is_align || is_log;

  // Same-thread GSR write in the accept cycle is bypassed to FALIGNDATA.
  assign align_eff = (gsr_wr_vld && (gsr_wr_tid == ifu_ffu_vis_tid)) ? gsr_wr_align
                                                                     : gsr[ifu_ffu_vis_tid];

  always_comb begin
    dec = idle_ctl();
    if (is_add) begin
      dec.add32    = ifu_ffu_vis_opf[1];
      dec.subtract = ifu_ffu_vis_opf[2];
      dec.cin      = ifu_ffu_vis_opf[2];
    end else if (is_align) begin
      dec.sel_add   = 1'b0;
      dec.sel_align = 1'b1;
      dec.align0    = (align_eff[2:1] == 2'b00);
      dec.align2    = (align_eff[2:1] == 2'b01);
      dec.align4    = (align_eff[2:1] == 2'b10);
      dec.align6    = (align_eff[2:1] == 2'b11);
      dec.align_odd = align_eff[0];
    end else if (is_log) begin
      dec.sel_add = 1'b0;
      dec.sel_log = 1'b1;
      case (ifu_ffu_vis_opf[4:1])
        4'd1:  begin dec.log_pass = 1'b0; dec.log_nor = 1'b1; end
        4'd2:  begin dec.log_pass = 1'b0; dec.log_nor = 1'b1; dec.inv_rs1 = 1'b1; end
        4'd3:  begin dec.pass_const = 1'b0; dec.pass_rs2 = 1'b1; dec.inv_rs2 = 1'b1; end
        4'd4:  begin dec.log_pass = 1'b0; dec.log_nor = 1'b1; dec.inv_rs2 = 1'b1; end
        4'd5:  begin dec.pass_const = 1'b0; dec.pass_rs1 = 1'b1; dec.inv_rs1 = 1'b1; end
        4'd6:  begin dec.log_pass = 1'b0; dec.log_xor = 1'b1; end
        4'd7:  begin dec.log_pass = 1'b0; dec.log_nand = 1'b1; end
        4'd8:  begin
          dec.log_pass = 1'b0; dec.log_nor = 1'b1; dec.inv_rs1 = 1'b1; dec.inv_rs2 = 1'b1;
        end
        4'd9:  begin dec.log_pass = 1'b0; dec.log_xor = 1'b1; dec.inv_rs1 = 1'b1; end
        4'd10: begin dec.pass_const = 1'b0; dec.pass_rs1 = 1'b1; end
        4'd11: begin dec.log_pass = 1'b0; dec.log_nand = 1'b1; dec.inv_rs1 = 1'b1; end
        4'd12: begin dec.pass_const = 1'b0; dec.pass_rs2 = 1'b1; end
        4'd13: begin dec.log_pass = 1'b0; dec.log_nand = 1'b1; dec.inv_rs2 = 1'b1; end
        4'd14: begin
          dec.log_pass = 1'b0; dec.log_nand = 1'b1; dec.inv_rs1 = 1'b1; dec.inv_rs2 = 1'b1;
        end
        4'd15: dec.constant = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      x_vld              <= 1'b0;
      x_tid              <= 2'b00;
      x_ctl              <= idle_ctl();
      visctl_illegal     <= 1'b0;
      visctl_illegal_tid <= 2'b00;
      for (int i = 0; i < 4; i++) gsr[i] <= 3'b000;
    end else begin
      if (gsr_wr_vld) gsr[gsr_wr_tid] <= gsr_wr_align;
      // A stalled X holds; otherwise it is replaced by the accepted op or emptied.
      if (!(x_vld && fpu_wb_stall)) begin
        if (accept && legal) begin
          x_vld <= 1'b1;
          x_tid <= ifu_ffu_vis_tid;
          x_ctl <= dec;
        end else begin
          x_vld <= 1'b0;
          x_tid <= 2'b00;
          x_ctl <= idle_ctl();
        end
      end
      visctl_illegal     <= accept && !legal;
      visctl_illegal_tid <= (accept && !legal) ? ifu_ffu_vis_tid : 2'b00;
    end
  end

  assign visctl_dp_vld          = x_vld;
  assign visctl_dp_tid          = x_tid;
  assign ctl_vis_sel_add        = x_ctl.sel_add;
  assign ctl_vis_sel_log        = x_ctl.sel_log;
  assign ctl_vis_sel_align      = x_ctl.sel_align;
  assign ctl_vis_add32          = x_ctl.add32;
  assign ctl_vis_subtract       = x_ctl.subtract;
  assign ctl_vis_cin            = x_ctl.cin;
  assign ctl_vis_align0         = x_ctl.align0;
  assign ctl_vis_align2         = x_ctl.align2;
  assign ctl_vis_align4         = x_ctl.align4;
  assign ctl_vis_align6         = x_ctl.align6;
  assign ctl_vis_align_odd      = x_ctl.align_odd;
  assign ctl_vis_log_sel_nor    = x_ctl.log_nor;
  assign ctl_vis_log_sel_nand   = x_ctl.log_nand;
  assign ctl_vis_log_sel_xor    = x_ctl.log_xor;
  assign ctl_vis_log_sel_pass   = x_ctl.log_pass;
  assign ctl_vis_log_invert_rs1 = x_ctl.inv_rs1;
  assign ctl_vis_log_invert_rs2 = x_ctl.inv_rs2;
  assign ctl_vis_log_constant   = x_ctl.constant;
  assign ctl_vis_log_pass_const = x_ctl.pass_const;
  assign ctl_vis_log_pass_rs1   = x_ctl.pass_rs1;
  assign ctl_vis_log_pass_rs2   = x_ctl.pass_rs2;

endmodule

// File: doc/sparc_ffu_visctl.md
# sparc_ffu_visctl

VIS control block for the FFU. It accepts decoded VIS issue requests (opf, thread) from the IFU and holds the per-thread GSR align field. It drives the one-hot `ctl_vis_*` selects that steer the combinational VIS datapath for partitioned add/subtract, FALIGNDATA and the 16 VIS logicals, and sequences each result through a single stallable execute register toward FFU writeback.

## Interface
Parameters: none; the thread count is fixed at 4.

- `rclk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ifu_ffu_vis_vld` in 1: issue request valid.
- `ifu_ffu_vis_opf` in 9: VIS opf field.
- `ifu_ffu_vis_tid` in 2: issuing thread.
- `visctl_ifu_rdy` out 1: request accepted this cycle when high together with `vld`.
- `gsr_wr_vld` in 1: GSR align write.
- `gsr_wr_tid` in 2: thread of the GSR write.
- `gsr_wr_align` in 3: new GSR.align value.
- `fpu_wb_stall` in 1: writeback cannot take the result this cycle.
- `ctl_vis_sel_add`, `ctl_vis_sel_log`, `ctl_vis_sel_align` out 1 each: output mux selects, one-hot.
- `ctl_vis_add32`, `ctl_vis_subtract`, `ctl_vis_cin` out 1 each: adder controls.
- `ctl_vis_align0`, `ctl_vis_align2`, `ctl_vis_align4`, `ctl_vis_align6` out 1 each: one-hot selects; `ctl_vis_align_odd` out 1.
- `ctl_vis_log_sel_nor`, `ctl_vis_log_sel_nand`, `ctl_vis_log_sel_xor`, `ctl_vis_log_sel_pass` out 1 each: one-hot logic selects.
- `ctl_vis_log_invert_rs1`, `ctl_vis_log_invert_rs2`, `ctl_vis_log_constant` out 1 each.
- `ctl_vis_log_pass_const`, `ctl_vis_log_pass_rs1`, `ctl_vis_log_pass_rs2` out 1 each: one-hot pass selects.
- `visctl_dp_vld` out 1: datapath result valid this cycle.
- `visctl_dp_tid` out 2: thread of the result.
- `visctl_illegal` out 1: unsupported opf, one-cycle pulse.
- `visctl_illegal_tid` out 2: thread of the illegal opf.

## Operation
**Legal opfs (hex).**
- FPADD16 050, FPADD32 052, FPSUB16 054, FPSUB32 056.
- FALIGNDATA 048.
- Even logicals 060–07E.
- Every other opf is illegal.

**Add ops.**
- `sel_add=1`.
- `add32` = opf[1].
- `subtract` = `cin` = opf[2].

**Align.**
- `sel_align=1`.
- Select `align{0,2,4,6}` from GSR.align[2:1] = 00/01/10/11.
- `align_odd` = GSR.align[0].

**Logicals.** `sel_log=1`. Per opf:
- 060 pass const 0.
- 062 nor.
- 064 nor, inv rs1.
- 066 pass rs2, inv rs2.
- 068 nor, inv rs2.
- 06A pass rs1, inv rs1.
- 06C xor.
- 06E nand.
- 070 nor, inv both.
- 072 xor, inv rs1.
- 074 pass rs1.
- 076 nand, inv rs1.
- 078 pass rs2.
- 07A nand, inv rs2.
- 07C nand, inv both.
- 07E pass const 1.
- For non-pass logicals, the pass selects are held at `pass_const=1`, `constant=0`.

**GSR.**
- Four 3-bit align registers, one per thread.
- A write updates the register at the next edge.
- A FALIGNDATA accepted in the same cycle as a same-thread GSR write uses the new value (bypass).

**Execute register X.**
- Holds valid, tid and the decoded selects.
- All `ctl_vis_*` outputs are driven directly from X flops; no combinational path from issue inputs.

**Idle encoding (X invalid).**
- `sel_add=1`, `align0=1`, `log_sel_pass=1`, `pass_const=1`.
- All other controls 0.
- This keeps every downstream mux one-hot.

**Illegal opf.**
- Accepted normally: `rdy` is not affected.
- Does not load X valid.
- Pulses `visctl_illegal` with its tid on the following cycle.

## Timing
**Reset.**
- X invalid (idle encoding); GSR = 0 for all threads.
- `visctl_dp_vld=0`, `visctl_illegal=0`, tids 0, `visctl_ifu_rdy=1`.
- Reset overrides any in-flight or stalled op; the op is dropped.

**Rdy and latency.**
- `visctl_ifu_rdy = !(X.vld & fpu_wb_stall)`.
- An op accepted in cycle N appears in X in cycle N+1: `visctl_dp_vld=1` and selects valid in N+1.
- Back-to-back issue gives throughput 1/cycle.

**Stall.**
- `fpu_wb_stall` with X valid holds X and all outputs unchanged, and forces `rdy=0`.
- X retires in the first cycle without stall.
- An accept in that same cycle replaces X at the edge: no bubble.

**GSR write while a FALIGNDATA is held in X.** The X align selects do not change; the align is captured at accept.

**No stall and no accept.** X goes invalid and outputs return to the idle encoding.

## Test plan
1. Reset, then FPSUB32 (056) tid 2 in cycle 1. Cycle 2: `sel_add=1`, `add32=1`, `subtract=1`, `cin=1`, `dp_vld=1`, `dp_tid=2`. Cycle 3: idle encoding.
2. GSR write tid 1 align=5 in the same cycle as FALIGNDATA tid 1. Next cycle: `sel_align=1`, `align4=1`, `align_odd=1`. A FALIGNDATA on tid 0 gives `align0=1`, `odd=0`.
3. Sweep all 16 even logicals 060–07E back-to-back. Each cycle's selects and inverts match the table; `dp_vld` is high for 16 consecutive cycles.
4. FPADD16 accepted, then `fpu_wb_stall` for 3 cycles while FNAND is offered. `rdy=0` for 3 cycles with the FPADD16 controls held; FNAND appears in X on the cycle after the stall drops.
5. Opf 051 tid 3. Next cycle: `visctl_illegal=1`, `illegal_tid=3`, `dp_vld=0`, idle encoding.
6. `reset` asserted during a stall with X valid. Next cycle: `dp_vld=0`, `rdy=1`, GSR reads 0.
